// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: holds all downstream resets for RST_CYCLES,
// then releases channels lowest-first with a STAGGER_CYCLES gap between them.
module reset_sequencer #(
  parameter int unsigned NUM_CHANNELS   = 4,
  parameter int unsigned RST_CYCLES     = 1,
  parameter int unsigned STAGGER_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_gate,
  input  logic                    sw_reset_req,
  output logic [NUM_CHANNELS-1:0] rst_out,
  output logic                    seq_done,
  output logic                    busy
);

  localparam int unsigned MAX_CYC = (RST_CYCLES > STAGGER_CYCLES) ? RST_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int unsigned IDX_W   = $clog2(NUM_CHANNELS) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CHANNELS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [NUM_CHANNELS-1:0] CH_ONE = NUM_CHANNELS'(1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_CHANNELS-1:0] rst_out_d;
  logic                    seq_done_d;
  logic                    busy_d;

  // State, counters and all outputs are registered together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_HOLD;
      cnt_q    <= '0;
      idx_q    <= '0;
      rst_out  <= '1;
      seq_done <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rst_out  <= rst_out_d;
      seq_done <= seq_done_d;
      busy     <= busy_d;
    end
  end

  // Next-state logic; a software request overrides gating and any pending release
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rst_out_d  = rst_out;
    seq_done_d = seq_done;
    busy_d     = busy;

    if (sw_reset_req) begin
      state_d    = S_HOLD;
      cnt_d      = '0;
      idx_d      = '0;
      rst_out_d  = '1;
      seq_done_d = 1'b0;
      busy_d     = 1'b1;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (!reset_gate) begin
            if (cnt_q == HOLD_LAST) begin
              cnt_d        = '0;
              idx_d        = IDX_ONE;
              rst_out_d[0] = 1'b0;
              if (NUM_CHANNELS == 1) begin
                state_d    = S_DONE;
                seq_done_d = 1'b1;
                busy_d     = 1'b0;
              end else begin
                state_d    = S_RELEASE;
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end

        S_RELEASE: begin
          if (!reset_gate) begin
            if (cnt_q == STAG_LAST) begin
              cnt_d     = '0;
              idx_d     = idx_q + IDX_ONE;
              rst_out_d = rst_out & ~(CH_ONE << idx_q);
              if (idx_q == IDX_LAST) begin
                state_d    = S_DONE;
                rst_out_d  = '0;
                seq_done_d = 1'b1;
                busy_d     = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end

        S_DONE: begin
          rst_out_d  = '0;
          seq_done_d = 1'b1;
          busy_d     = 1'b0;
        end

        default: begin
          state_d = S_HOLD;
        end
      endcase
    end
  end

endmodule
